// File: rtl/mmu_map_loader.sv
// Bulk writer for the task mapping RAM: LOAD fills one task with base+slot, COPY duplicates
// a task's entries, INIT fills every task. RAM cycles are only issued while the CPU leaves the port free.
module mmu_map_loader #(
  parameter int TASKS = 32,
  parameter int SLOTS = 8
) (
  input  logic                                  CLKX4,
  input  logic                                  RESET,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [1:0]                            cmd_op,
  input  logic [$clog2(TASKS)-1:0]              cmd_task,
  input  logic [$clog2(TASKS)-1:0]              cmd_src_task,
  input  logic [7:0]                            cmd_base,
  input  logic                                  cpu_busy,
  output logic [$clog2(TASKS)+$clog2(SLOTS)-1:0] ram_addr,
  output logic                                  ram_nrd,
  output logic                                  ram_nwr,
  output logic [7:0]                            ram_wdata,
  output logic                                  ram_oe,
  input  logic [7:0]                            ram_rdata,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);
  localparam int TW = $clog2(TASKS);
  localparam int SW = $clog2(SLOTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_CAP  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_INIT = 2'd2;

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
  localparam logic [TW-1:0] TASK_LAST = TW'(TASKS - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [TW-1:0] dst_q, dst_d;
  logic [TW-1:0] src_q, src_d;
  logic [7:0]    base_q, base_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    rbuf_q, rbuf_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic accept;
  logic wr_en;
  logic rd_en;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    base_d  = base_q;
    slot_d  = slot_q;
    tcnt_d  = tcnt_q;
    rbuf_d  = rbuf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          dst_d  = cmd_task;
          src_d  = cmd_src_task;
          base_d = cmd_base;
          slot_d = '0;
          tcnt_d = '0;
          case (cmd_op)
            OP_LOAD, OP_INIT: state_d = S_WR;
            OP_COPY:          state_d = S_RD;
            default:          err_d   = 1'b1;
          endcase
        end
      end
      S_WR: begin
        // A stalled write leaves every counter untouched so it simply retries.
        if (!cpu_busy) begin
          if (slot_q != SLOT_LAST) begin
            slot_d  = slot_q + SW'(1);
            state_d = (op_q == OP_COPY) ? S_RD : S_WR;
          end else if (op_q == OP_INIT && tcnt_q != TASK_LAST) begin
            slot_d = '0;
            tcnt_d = tcnt_q + TW'(1);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_RD: begin
        if (!cpu_busy) state_d = S_CAP;
      end
      default: begin
        // Read data arrives the cycle after the strobe, independent of the CPU.
        rbuf_d  = ram_rdata;
        state_d = S_WR;
      end
    endcase
  end

  always_ff @(posedge CLKX4) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      base_q  <= '0;
      slot_q  <= '0;
      tcnt_q  <= '0;
      rbuf_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      base_q  <= base_d;
      slot_q  <= slot_d;
      tcnt_q  <= tcnt_d;
      rbuf_q  <= rbuf_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_en = (state_q == S_WR) && !cpu_busy && !RESET;
  assign rd_en = (state_q == S_RD) && !cpu_busy && !RESET;

  always_comb begin
    if (state_q == S_RD)       ram_addr = {src_q, slot_q};
    else if (op_q == OP_INIT)  ram_addr = {tcnt_q, slot_q};
    else                       ram_addr = {dst_q, slot_q};
  end

  assign ram_wdata = (op_q == OP_COPY) ? rbuf_q : base_q + 8'(slot_q);
  assign ram_nwr   = !wr_en;
  assign ram_nrd   = !rd_en;
  assign ram_oe    = wr_en;
  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE) && !RESET;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mmu_map_loader.sv
// Directed bench for mmu_map_loader with a behavioural 256x8 RAM and a strobe monitor.
module tb_mmu_map_loader;
  logic       CLKX4 = 1'b0;
  logic       RESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [4:0] cmd_task = 5'd0;
  logic [4:0] cmd_src_task = 5'd0;
  logic [7:0] cmd_base = 8'd0;
  logic       cpu_busy = 1'b0;
  logic [7:0] ram_addr;
  logic       ram_nrd;
  logic       ram_nwr;
  logic [7:0] ram_wdata;
  logic       ram_oe;
  logic [7:0] ram_rdata;
  logic       busy;
  logic       done;
  logic       err;

  mmu_map_loader dut (
    .CLKX4(CLKX4), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_task(cmd_task), .cmd_src_task(cmd_src_task), .cmd_base(cmd_base),
    .cpu_busy(cpu_busy), .ram_addr(ram_addr), .ram_nrd(ram_nrd), .ram_nwr(ram_nwr),
    .ram_wdata(ram_wdata), .ram_oe(ram_oe), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLKX4 = ~CLKX4;

  // RAM model; pre_req seeds task 2 with 0xA0..0xA7 and clears the rest.
  logic [7:0] mem [256];
  logic       pre_req = 1'b1;
  always @(posedge CLKX4) begin
    if (pre_req) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i >= 16 && i < 24) ? 8'(160 + i - 16) : 8'h00;
    end else begin
      if (!ram_nwr) mem[ram_addr] <= ram_wdata;
      if (!ram_nrd) ram_rdata <= mem[ram_addr];
    end
  end

  // Edge-indexed monitor: cyc is the number of the edge being sampled.
  int         cyc = 0;
  logic [7:0] wq_addr [$];
  logic [7:0] wq_data [$];
  int         wq_cyc [$];
  int         n_rd = 0, n_viol = 0, n_done = 0, n_errp = 0;
  always @(posedge CLKX4) begin
    cyc <= cyc + 1;
    if (!ram_nwr) begin
      wq_addr.push_back(ram_addr);
      wq_data.push_back(ram_wdata);
      wq_cyc.push_back(cyc);
    end
    if (!ram_nrd) n_rd <= n_rd + 1;
    if ((!ram_nwr || !ram_nrd) && (cpu_busy || RESET)) n_viol <= n_viol + 1;
    if (ram_oe !== !ram_nwr) n_viol <= n_viol + 1;
    if (done) n_done <= n_done + 1;
    if (err) n_errp <= n_errp + 1;
  end

  int n_chk = 0, n_err = 0;
  int c0, w0, r0, dcyc, d0, e0, v0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKX4);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] t, input logic [4:0] s,
                       input logic [7:0] b);
    cmd_op = op; cmd_task = t; cmd_src_task = s; cmd_base = b; cmd_valid = 1'b1;
    w0 = wq_addr.size();
    r0 = n_rd;
    tick();
    cmd_valid = 1'b0;
    c0 = cyc - 1;
  endtask

  // Returns the cycle (accept edge = 0) in which done is seen, or -1 on timeout.
  task automatic wait_done(input int maxc, input bit tog, output int dc);
    dc = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (done) begin
        dc = cyc - c0;
        break;
      end
      if (tog) cpu_busy = ~cpu_busy;
    end
  endtask

  task automatic check_load(input string tag, input logic [4:0] t, input logic [7:0] b);
    chk({tag, " nwrites"}, 32'(wq_addr.size() - w0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (w0 + i < wq_addr.size()) begin
        chk({tag, " addr"}, 32'(wq_addr[w0 + i]), 32'({t, 3'(i)}));
        chk({tag, " data"}, 32'(wq_data[w0 + i]), 32'(8'(b + 8'(i))));
        chk({tag, " wcycle"}, 32'(wq_cyc[w0 + i] - c0), 32'(i + 1));
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    pre_req = 1'b0;
    RESET = 1'b0;
    #1;
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset nrd", 32'(ram_nrd), 32'd1);
    chk("reset nwr", 32'(ram_nwr), 32'd1);
    chk("reset oe", 32'(ram_oe), 32'd0);

    // LOAD task 3, base 0x80
    issue(2'd0, 5'd3, 5'd0, 8'h80);
    chk("load3 busy", 32'(busy), 32'd1);
    wait_done(40, 1'b0, dcyc);
    chk("load3 done cycle", 32'(dcyc), 32'd9);
    chk("load3 busy at done", 32'(busy), 32'd0);
    chk("load3 ready at done", 32'(cmd_ready), 32'd1);
    check_load("load3", 5'd3, 8'h80);
    tick();
    chk("load3 done one cycle", 32'(done), 32'd0);

    // LOAD task 31, base 0xFE: data and address wrap
    issue(2'd0, 5'd31, 5'd0, 8'hFE);
    wait_done(40, 1'b0, dcyc);
    chk("load31 done cycle", 32'(dcyc), 32'd9);
    check_load("load31", 5'd31, 8'hFE);
    chk("load31 mem 0xFA", 32'(mem[8'hFA]), 32'h00);

    // COPY task 2 -> 5 with a LOAD request held mid-operation
    e0 = n_errp;
    issue(2'd1, 5'd5, 5'd2, 8'h00);
    dcyc = -1;
    for (int j = 1; j < 60; j++) begin
      if (j == 4) begin
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_task = 5'd0; cmd_base = 8'h55;
      end
      if (j == 7) cmd_valid = 1'b0;
      tick();
      if (done) begin
        dcyc = cyc - c0;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("copy done cycle", 32'(dcyc), 32'd25);
    chk("copy nreads", 32'(n_rd - r0), 32'd8);
    chk("copy nwrites", 32'(wq_addr.size() - w0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (w0 + i < wq_addr.size()) begin
        chk("copy addr", 32'(wq_addr[w0 + i]), 32'(8'h28 + i));
        chk("copy data", 32'(wq_data[w0 + i]), 32'(8'hA0 + i));
      end
    end
    if (wq_addr.size() >= w0 + 8)
      chk("copy last wcycle", 32'(wq_cyc[w0 + 7] - c0), 32'd24);
    chk("copy ignored cmd mem0", 32'(mem[8'h00]), 32'h00);
    chk("copy ignored cmd no err", 32'(n_errp - e0), 32'd0);

    // Reserved op
    e0 = n_errp;
    issue(2'd3, 5'd7, 5'd0, 8'h11);
    chk("rsvd err pulse", 32'(err), 32'd1);
    chk("rsvd busy", 32'(busy), 32'd0);
    chk("rsvd ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("rsvd err clears", 32'(err), 32'd0);
    chk("rsvd err count", 32'(n_errp - e0), 32'd1);
    chk("rsvd no writes", 32'(wq_addr.size() - w0), 32'd0);
    chk("rsvd no reads", 32'(n_rd - r0), 32'd0);

    // RESET during cycle 4 of a LOAD
    d0 = n_done;
    issue(2'd0, 5'd1, 5'd0, 8'h10);
    repeat (3) tick();
    RESET = 1'b1;
    #1;
    chk("rst nwr gated", 32'(ram_nwr), 32'd1);
    chk("rst oe gated", 32'(ram_oe), 32'd0);
    chk("rst ready low", 32'(cmd_ready), 32'd0);
    tick();
    RESET = 1'b0;
    #1;
    chk("rst idle busy", 32'(busy), 32'd0);
    chk("rst ready", 32'(cmd_ready), 32'd1);
    chk("rst partial writes", 32'(wq_addr.size() - w0), 32'd3);
    chk("rst mem 0x0A", 32'(mem[8'h0A]), 32'h12);
    chk("rst mem 0x0B", 32'(mem[8'h0B]), 32'h00);
    repeat (3) tick();
    chk("rst no done", 32'(n_done - d0), 32'd0);
    issue(2'd0, 5'd1, 5'd0, 8'h20);
    wait_done(40, 1'b0, dcyc);
    chk("post-rst load done cycle", 32'(dcyc), 32'd9);
    check_load("post-rst load", 5'd1, 8'h20);

    // INIT base 0x40 with cpu_busy toggling every cycle, starting high
    v0 = n_viol;
    issue(2'd2, 5'd0, 5'd0, 8'h40);
    cpu_busy = 1'b1;
    wait_done(700, 1'b1, dcyc);
    cpu_busy = 1'b0;
    chk("init done cycle", 32'(dcyc), 32'd513);
    chk("init nwrites", 32'(wq_addr.size() - w0), 32'd256);
    if (wq_addr.size() >= w0 + 256) begin
      chk("init first wcycle", 32'(wq_cyc[w0] - c0), 32'd2);
      chk("init last addr", 32'(wq_addr[w0 + 255]), 32'hFF);
    end
    for (int a = 0; a < 256; a++)
      chk("init mem", 32'(mem[8'(a)]), 32'(8'h40 + (a % 8)));
    chk("strobe vs cpu_busy/reset violations", 32'(n_viol - v0), 32'd0);
    chk("total violations", 32'(n_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mmu_map_loader.md
# mmu_map_loader

Hardware sequencer that bulk-writes task map entries into the 256×8 MMU mapping RAM (32 tasks × 8 slots). Supported operations are load one task, copy one task to another, and initialise all tasks. It shares the RAM port with the CPU: it only issues a RAM cycle when the CPU-side logic does not own the port. Firmware uses it for fast task creation and fork-style map duplication instead of 8–256 individual CPU writes.

## Interface
Parameters:
- `TASKS`, 32: number of task keys; task key width is log2(`TASKS`) = 5.
- `SLOTS`, 8: map entries per task; slot index width is 3.

Ports:
- `CLKX4`  in  1  system clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  loader idle; a command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  operation code:
  - 00 = LOAD task
  - 01 = COPY task
  - 10 = INIT all tasks
  - 11 = reserved
- `cmd_task`  in  5  destination task key.
- `cmd_src_task`  in  5  source task key (COPY only).
- `cmd_base`  in  8  first entry value (LOAD and INIT).
- `cpu_busy`  in  1  CPU/translation path owns the MMU RAM this cycle.
- `ram_addr`  out  8  RAM address = {task, slot}.
- `ram_nrd`  out  1  active-low read strobe.
- `ram_nwr`  out  1  active-low write strobe.
- `ram_wdata`  out  8  write data.
- `ram_oe`  out  1  drive enable for `ram_wdata`; equals `!ram_nwr`.
- `ram_rdata`  in  8  read data; valid the cycle after a read strobe.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when an operation completes.
- `err`  out  1  one-cycle pulse when a reserved op is received.

## Operation
- States: IDLE, WR, RD, CAP.
- Registers:
  - `op`
  - `dst` (5 bits)
  - `src` (5 bits)
  - `base` (8 bits)
  - `slot` (3 bits)
  - `tcnt` (5 bits, task counter for INIT)
  - `rbuf` (8 bits)
- IDLE: `cmd_ready` = 1. On accept, capture all cmd fields and set `slot` = 0, `tcnt` = 0.
  - LOAD → WR.
  - COPY → RD.
  - INIT → WR.
  - Reserved → stay in IDLE, pulse `err` the next cycle, no RAM activity.
- WR: strobe is combinational.
  - `ram_nwr` = 0 iff state == WR && !`cpu_busy` && !`RESET`.
  - Address:
    - LOAD and COPY: {`dst`, `slot`}.
    - INIT: {`tcnt`, `slot`}.
  - Data:
    - LOAD and INIT: `base` + `slot`, 8-bit modulo 256 (0xFE + 3 = 0x01).
    - COPY: `rbuf`.
  - If `cpu_busy` = 1: stall, no counter change, strobes high.
  - After a completed write:
    - If `slot` ≠ 7: `slot`++. Next state is WR (LOAD/INIT) or RD (COPY).
    - If `slot` == 7 and op is INIT with `tcnt` ≠ 31: `slot` wraps to 0, `tcnt`++, stay in WR.
    - Otherwise: IDLE, with `done` = 1 for one cycle.
- RD (COPY only):
  - `ram_nrd` = 0 iff !`cpu_busy` && !`RESET`, address {`src`, `slot`}.
  - If stalled, stay in RD; otherwise → CAP.
- CAP: `rbuf` ← `ram_rdata` unconditionally, no strobe, → WR. `cpu_busy` is ignored in CAP.
- `src` == `dst` is legal: each value is rewritten unchanged.
- `cmd_valid` while not in IDLE is ignored. It is not queued and does not raise `err`.
- `busy` = (state ≠ IDLE). `cmd_ready` = (state == IDLE) && !`RESET`.
- When no strobe is active, `ram_addr` and `ram_wdata` are don't-care but stable (registered values).

## Timing
- Reset values: state IDLE; `cmd_ready` 1 after reset is released; `busy` 0; `done` 0; `err` 0; `ram_nrd` 1; `ram_nwr` 1; `ram_oe` 0; all counters 0.
- `RESET` asserted mid-operation:
  - Strobes deassert in the same cycle (combinational gating).
  - State returns to IDLE at the next edge.
  - No `done` is pulsed. Partially written entries remain in the RAM.
- Unstalled latency, with the accept edge as cycle 0:
  - LOAD: writes in cycles 1–8; `done` in cycle 9, with `busy` = 0 and `cmd_ready` = 1.
  - COPY: 3 cycles per entry (RD, CAP, WR); last write in cycle 24; `done` in cycle 25.
  - INIT: 256 writes in cycles 1–256; `done` in cycle 257.
- Each cycle of `cpu_busy` high during RD or WR adds exactly one cycle.
- The loader never drives a strobe in a cycle where `cpu_busy` = 1.
- `done` and `err` are registered outputs.

## Test plan
- LOAD, task 3, `cmd_base` 0x80, `cpu_busy` = 0 → writes to addresses 0x18–0x1F with data 0x80–0x87, one per cycle in cycles 1–8; `done` in cycle 9.
- LOAD, task 31, `cmd_base` 0xFE → data 0xFE, 0xFF, 0x00–0x05 at addresses 0xF8–0xFF (checks data and address wrap).
- COPY, src 2 to dst 5, RAM model preloaded with 0xA0–0xA7 at 0x10–0x17 → reads 0x10–0x17 and writes the same values to 0x28–0x2F; `done` at cycle 25.
- INIT, `cmd_base` 0x40, with `cpu_busy` toggled 1/0 every cycle → all 256 entries written with 0x40 + slot; no strobe ever coincides with `cpu_busy` = 1; `done` at cycle 513.
- `RESET` pulsed during cycle 4 of a LOAD → strobes high that cycle, IDLE next edge, no `done`; a following LOAD completes normally.
- `cmd_op` = 11 → `err` pulses once, no RAM strobes; a second `cmd_valid` arriving mid-COPY is ignored.
